// File: rtl/snes_poll_scheduler_if.sv
// Pad-side and game-side signals of the SNES poll scheduler.
// master = the scheduler, slave = the pad connector / game logic side.
interface snes_poll_scheduler_if;
  logic        enable;
  logic        data0;
  logic        data1;
  logic        dclock;
  logic        dlatch;
  logic [11:0] buttons0;
  logic [11:0] buttons1;
  logic [11:0] pressed0;
  logic [11:0] pressed1;
  logic        valid;
  logic        busy;
  logic        present0;
  logic        present1;

  modport master (
    input  enable, data0, data1,
    output dclock, dlatch, buttons0, buttons1, pressed0, pressed1,
           valid, busy, present0, present1
  );

  modport slave (
    output enable, data0, data1,
    input  dclock, dlatch, buttons0, buttons1, pressed0, pressed1,
           valid, busy, present0, present1
  );
endinterface

// File: rtl/snes_poll_scheduler.sv
// Polls two SNES pads over one shared dclock/dlatch pair and publishes per-frame button words.
// Optional pad-presence detection is enabled with `define SNES_PAD_DETECT_EN.
module snes_poll_scheduler #(
  parameter int CLK_DIV     = 600,
  parameter int POLL_CYCLES = 833333
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  snes_poll_scheduler_if.master bus
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] POLL_MAX   = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_READ,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_poll;
  logic [HW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic          r_high;
  logic [15:0]   r_shadow0;
  logic [15:0]   r_shadow1;
  logic          r_dclock;
  logic          r_dlatch;
  logic          r_busy;
  logic          r_valid;
  logic [11:0]   r_buttons0;
  logic [11:0]   r_buttons1;
  logic [11:0]   r_pressed0;
  logic [11:0]   r_pressed1;

  state_t        w_state_nxt;
  logic [HW-1:0] w_cnt_nxt;
  logic [3:0]    w_bit_nxt;
  logic          w_high_nxt;
  logic          w_start;
  logic          w_sample;
  logic          w_due;
  logic          w_publish;
  logic [11:0]   w_new0;
  logic [11:0]   w_new1;

  assign w_due     = (r_poll == POLL_MAX);
  assign w_publish = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_high_nxt  = r_high;
    w_start     = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_due && bus.enable) begin
          w_state_nxt = S_LATCH;
          w_cnt_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      S_LATCH: begin
        if (r_cnt == LATCH_LAST) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
          w_high_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_READ: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (!r_high) begin
            // Pads shift on the dclock rising edge, so sample just before it.
            w_sample   = 1'b1;
            w_high_nxt = 1'b1;
          end else if (r_bit == 4'd15) begin
            w_state_nxt = S_DONE;
            w_high_nxt  = 1'b0;
          end else begin
            w_bit_nxt  = r_bit + 1'b1;
            w_high_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_bit_nxt   = 4'd0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SNES_PAD_DETECT_EN
  logic r_present0;
  logic r_present1;
  logic w_pres0;
  logic w_pres1;

  // A missing pad pulls data low, so its trailing four bits read back as set.
  assign w_pres0 = (r_shadow0[15:12] == 4'h0);
  assign w_pres1 = (r_shadow1[15:12] == 4'h0);
  assign w_new0  = w_pres0 ? r_shadow0[11:0] : 12'h000;
  assign w_new1  = w_pres1 ? r_shadow1[11:0] : 12'h000;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_present0 <= 1'b1;
      r_present1 <= 1'b1;
    end else if (w_publish) begin
      r_present0 <= w_pres0;
      r_present1 <= w_pres1;
    end
  end

  assign bus.present0 = r_present0;
  assign bus.present1 = r_present1;
`else
  assign w_new0       = r_shadow0[11:0];
  assign w_new1       = r_shadow1[11:0];
  assign bus.present0 = 1'b1;
  assign bus.present1 = 1'b1;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_poll     <= '0;
      r_cnt      <= '0;
      r_bit      <= 4'd0;
      r_high     <= 1'b0;
      r_shadow0  <= 16'h0000;
      r_shadow1  <= 16'h0000;
      r_dclock   <= 1'b1;
      r_dlatch   <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_buttons0 <= 12'h000;
      r_buttons1 <= 12'h000;
      r_pressed0 <= 12'h000;
      r_pressed1 <= 12'h000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_high   <= w_high_nxt;
      r_dlatch <= (w_state_nxt == S_LATCH);
      r_dclock <= !((w_state_nxt == S_READ) && !w_high_nxt);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_valid  <= w_publish;
      if (w_start) begin
        r_poll <= '0;
      end else if (!w_due) begin
        r_poll <= r_poll + 1'b1;
      end
      // First bit read (B) ends up in bit 0 after sixteen shifts.
      if (w_sample) begin
        r_shadow0 <= {~bus.data0, r_shadow0[15:1]};
        r_shadow1 <= {~bus.data1, r_shadow1[15:1]};
      end
      if (w_publish) begin
        r_buttons0 <= w_new0;
        r_buttons1 <= w_new1;
        r_pressed0 <= w_new0 & ~r_buttons0;
        r_pressed1 <= w_new1 & ~r_buttons1;
      end else begin
        r_pressed0 <= 12'h000;
        r_pressed1 <= 12'h000;
      end
    end
  end

  assign bus.dclock   = r_dclock;
  assign bus.dlatch   = r_dlatch;
  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.buttons0 = r_buttons0;
  assign bus.buttons1 = r_buttons1;
  assign bus.pressed0 = r_pressed0;
  assign bus.pressed1 = r_pressed1;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Bench for snes_poll_scheduler with CLK_DIV=4, POLL_CYCLES=200 and a pair of shift-register pad models.
module tb_snes_poll_scheduler;

  logic clk;
  logic reset;

  snes_poll_scheduler_if bus ();

  snes_poll_scheduler #(
    .CLK_DIV     (4),
    .POLL_CYCLES (200)
  ) dut (
    .i_clock (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] b0;
    logic [11:0] b1;
    logic [11:0] p0;
    logic [11:0] p1;
    logic        pr0;
    logic        pr1;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] pat0;
  logic [11:0] pat1;
  logic        tie1;
  logic [11:0] prev0;
  logic [11:0] prev1;
  logic [15:0] sr0 = 16'hFFFF;
  logic [15:0] sr1 = 16'hFFFF;

  function automatic logic [15:0] raw_of(input logic [11:0] pat);
    return {4'hF, ~pat};
  endfunction

  // Pad model: parallel load on latch, shift toward bit 0 on each dclock rise.
  always @(posedge bus.dlatch or posedge bus.dclock) begin
    if (bus.dlatch) begin
      sr0 <= raw_of(pat0);
      sr1 <= raw_of(pat1);
    end else begin
      sr0 <= {1'b1, sr0[15:1]};
      sr1 <= {1'b1, sr1[15:1]};
    end
  end

  assign bus.data0 = sr0[0];
  assign bus.data1 = tie1 ? 1'b0 : sr1[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_expect();
    logic [15:0] r0;
    logic [15:0] r1;
    exp_t        e;
    r0    = raw_of(pat0);
    r1    = tie1 ? 16'h0000 : raw_of(pat1);
    e.pr0 = 1'b1;
    e.pr1 = 1'b1;
`ifdef SNES_PAD_DETECT_EN
    e.pr0 = (r0[15:12] == 4'hF);
    e.pr1 = (r1[15:12] == 4'hF);
`endif
    e.b0  = e.pr0 ? ~r0[11:0] : 12'h000;
    e.b1  = e.pr1 ? ~r1[11:0] : 12'h000;
    e.p0  = e.b0 & ~prev0;
    e.p1  = e.b1 & ~prev1;
    prev0 = e.b0;
    prev1 = e.b1;
    sb_q.push_back(e);
  endtask

  // n = edges until dlatch is first seen high, -1 if it never rises within limit.
  task automatic wait_dlatch(input int limit, output int n, output int vcount);
    n      = -1;
    vcount = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.valid) vcount++;
      if (bus.dlatch) begin
        n = i;
        break;
      end
    end
  endtask

  // Entered on the cycle dlatch first reads high; runs to the valid pulse.
  task automatic monitor_frame(input int drop_at);
    int   cyc;
    int   lat_len;
    int   pulses;
    int   badw;
    int   low_run;
    logic got;
    exp_t e;
    cyc     = 0;
    lat_len = 0;
    pulses  = 0;
    badw    = 0;
    low_run = 0;
    got     = 1'b0;
    while (cyc < 400) begin
      if (cyc == drop_at) bus.enable = 1'b0;
      if (bus.dlatch) lat_len++;
      if (!bus.dclock) begin
        low_run++;
      end else if (low_run > 0) begin
        pulses++;
        if (low_run != 4) badw++;
        low_run = 0;
      end
      if (bus.valid) begin
        got = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    chk("valid_seen", got, 1);
    if (got) begin
      chk("valid_latency", cyc, 137);
      chk("latch_width", lat_len, 8);
      chk("dclock_pulses", pulses, 16);
      chk("dclock_width_bad", badw, 0);
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("buttons0", bus.buttons0, e.b0);
        chk("buttons1", bus.buttons1, e.b1);
        chk("pressed0", bus.pressed0, e.p0);
        chk("pressed1", bus.pressed1, e.p1);
        chk("present0", bus.present0, e.pr0);
        chk("present1", bus.present1, e.pr1);
      end
      step();
      chk("valid_one_cycle", bus.valid, 0);
      chk("pressed_one_cycle", {bus.pressed0, bus.pressed1}, 0);
    end
  endtask

  initial begin
    int n;
    int v;
    reset      = 1'b1;
    bus.enable = 1'b1;
    pat0       = 12'h010;
    pat1       = 12'h100;
    tie1       = 1'b0;
    prev0      = 12'h000;
    prev1      = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dclock", bus.dclock, 1);
    chk("rst_dlatch", bus.dlatch, 0);
    chk("rst_buttons", {bus.buttons0, bus.buttons1}, 0);
    chk("rst_pressed", {bus.pressed0, bus.pressed1}, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_present", {bus.present0, bus.present1}, 2'b11);

    // Frame 1: up on pad 0, A on pad 1.
    push_expect();
    reset = 1'b0;
    wait_dlatch(300, n, v);
    chk("first_latch_delay", n, 200);
    chk("busy_in_frame", bus.busy, 1);
    monitor_frame(-1);

    // Frame 2: held buttons give no new presses; frame period is POLL_CYCLES.
    push_expect();
    wait_dlatch(300, n, v);
    chk("poll_period", n, 200 - 138);
    monitor_frame(-1);

    // Frame 3: release up.
    pat0 = 12'h000;
    push_expect();
    wait_dlatch(300, n, v);
    monitor_frame(-1);

    // Frame 4: enable dropped 10 cycles into READ still completes.
    pat0 = 12'h001;
    push_expect();
    wait_dlatch(300, n, v);
    monitor_frame(18);
    wait_dlatch(1000, n, v);
    chk("no_latch_after_disable", n, -1);

    // Reset during bit 7 of READ.
    bus.enable = 1'b1;
    wait_dlatch(10, n, v);
    chk("resume_latch", n > 0, 1);
    repeat (66) step();
    reset = 1'b1;
    step();
    chk("midrst_dclock", bus.dclock, 1);
    chk("midrst_dlatch", bus.dlatch, 0);
    chk("midrst_buttons", {bus.buttons0, bus.buttons1}, 0);
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_busy", bus.busy, 0);
    prev0 = 12'h000;
    prev1 = 12'h000;
    pat0  = 12'h010;
    push_expect();
    reset = 1'b0;
    wait_dlatch(300, n, v);
    chk("latch_after_midrst", n, 200);
    chk("no_valid_after_midrst", v, 0);
    monitor_frame(-1);

    // enable low from reset: no frames at all.
    reset      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) step();
    prev0 = 12'h000;
    prev1 = 12'h000;
    reset = 1'b0;
    wait_dlatch(1000, n, v);
    chk("no_latch_enable_low", n, -1);
    chk("no_valid_enable_low", v, 0);

    // Pad 1 data tied low all frame.
    tie1 = 1'b1;
    pat0 = 12'h801;
    push_expect();
    bus.enable = 1'b1;
    wait_dlatch(10, n, v);
    chk("tie_latch", n > 0, 1);
    monitor_frame(-1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_poll_scheduler.md
Name: snes_poll_scheduler

Overview:
Sequences the SNES serial pad protocol from the system clock and shares one dclock/dlatch pair between two pads, whose data lines are read in parallel. Issues a latch/clock frame at a fixed poll rate, de-serialises both pads, and publishes debounced-per-frame button words plus one-cycle press events. Sits between the pad connector pins and the game logic (snake direction, start/pause), replacing free-running pad readers.

Parameters:
CLK_DIV, 600, system clock cycles per half serial bit (50 MHz / 1200 = 41.667 kHz bit rate); must be >= 2
POLL_CYCLES, 833333, system clock cycles between frame starts (~60 Hz at 50 MHz); counter width $clog2(POLL_CYCLES)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = polling allowed; sampled only in IDLE
data0  input  1  pad 0 serial data, active-low buttons
data1  input  1  pad 1 serial data, active-low buttons
dclock  output  1  shared pad clock; idles high
dlatch  output  1  shared pad latch; idles low
buttons0  output  12  pad 0 state, 1 = pressed; bit order b,y,sel,start,up,down,left,right,a,x,l,r = bits 0..11
buttons1  output  12  pad 1 state, same order
pressed0  output  12  pad 0 newly-pressed bits, one-cycle pulse
pressed1  output  12  pad 1 newly-pressed bits, one-cycle pulse
valid  output  1  one-cycle pulse: buttons/pressed updated this cycle
busy  output  1  1 while a frame is in progress (state != IDLE)
present0  output  1  pad 0 detected (see Optional Feature)
present1  output  1  pad 1 detected

Behaviour:
- Reset values: state IDLE, dclock=1, dlatch=0, buttons0/1=0, pressed0/1=0, valid=0, busy=0, present0/1=1, poll counter=0, bit index=0, half-bit counter=0, shadow shift registers=0.
- Poll counter: increments every cycle, saturates at POLL_CYCLES-1; cleared to 0 on the cycle a frame starts. "due" = counter == POLL_CYCLES-1.
- IDLE: if due && enable -> LATCH. Otherwise stay. First frame after reset starts POLL_CYCLES cycles after reset release.
- LATCH: dlatch=1 for exactly 2*CLK_DIV cycles, dclock=1 -> READ, bit index 0.
- READ: 16 bits; per bit dclock=0 for CLK_DIV cycles, then dclock=1 for CLK_DIV cycles. data0/data1 sampled on the last cycle of the low phase, inverted, shifted into per-pad 16-bit shadow registers. After bit 15's high phase -> DONE.
- DONE (1 cycle): buttons_n <= shadow bits 0..11; pressed_n <= new & ~old buttons_n; valid=1 registered so valid, buttons and pressed change on the same edge and are seen together for one cycle; -> IDLE.
- Latency: valid high 34*CLK_DIV+1 cycles after the cycle dlatch first goes high.
- Shadow bits 12..15 are not published; used only by the optional feature.
- pressed_n and valid are 0 in every cycle other than the one following DONE.
- enable deasserted mid-frame: frame completes normally including valid; no new frame until enable=1 and due.
- POLL_CYCLES < 34*CLK_DIV+2: counter saturates, frames run back-to-back with exactly one IDLE cycle between them.
- reset mid-frame: next cycle dclock=1, dlatch=0, all outputs to reset values; partial shadow data discarded; no valid pulse.
- dclock/dlatch are registered outputs, glitch-free.

Optional Feature:
Macro SNES_PAD_DETECT_EN.
- Defined: present_n <= 1 iff raw bits 12..15 of that frame were all high (inverted shadow = 0). When present_n = 0, buttons_n forced to 0 and pressed_n to 0 for that frame. present_n updates in the DONE-following cycle with valid.
- Not defined: present0/present1 tied to 1; buttons published unconditionally (floating-low pad reads as 12'hFFF).

Test Plan:
- CLK_DIV=4, POLL_CYCLES=200; hold reset 3 cycles -> dclock=1, dlatch=0, buttons=0, valid=0, busy=0; first dlatch rise exactly 200 cycles after reset release.
- Pad0 drives bit4 low (up), pad1 bit8 low (a), others high -> dlatch high 8 cycles, 16 dclock low pulses of 4 cycles; valid pulse 137 cycles after dlatch rise; buttons0=12'h010, buttons1=12'h100, pressed0=12'h010, pressed1=12'h100.
- Hold same pattern a second frame -> buttons unchanged, pressed0=pressed1=0 with valid; release up on frame 3 -> buttons0=0, pressed0=0.
- enable=0 from reset -> no dlatch for 1000 cycles; drop enable 10 cycles into READ -> frame finishes, one valid, then no further dlatch.
- Assert reset at bit 7 of READ -> next cycle dclock=1, dlatch=0, buttons=0, no valid; next frame starts 200 cycles after reset release.
- data1 tied low all frame -> with SNES_PAD_DETECT_EN present1=0, buttons1=0; without it buttons1=12'hFFF, present1=1.
